// File: rtl/trace_capture_buffer.sv
// Trace capture FIFO: records committed instructions once armed, stops POST_TRIG records after a masked trigger match.
// First-word-fall-through output (visible one cycle after the push edge); upstream has no backpressure, so a full FIFO drops records and counts them.
module trace_capture_buffer #(
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 4,
    parameter int OVF_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic                     clear,
    input  logic [31:0]              trig_instr,
    input  logic [31:0]              trig_mask,
    input  logic                     trace_valid,
    input  logic [31:0]              trace_instr,
    input  logic [31:0]              trace_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_addr,
    output logic [$clog2(DEPTH):0]   level,
    output logic [OVF_W-1:0]         overflow_count,
    output logic                     triggered,
    output logic                     done
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PCW = (POST_TRIG < 2) ? 1 : $clog2(POST_TRIG + 1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       r_state;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_level;
    logic [OVF_W-1:0] r_ovf;
    logic [PCW-1:0]   r_post_cnt;
    logic             r_triggered;
    logic [63:0]      r_mem [DEPTH];

    logic w_capturing;
    logic w_offer;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_match;

    // clear wins over every other request in its cycle, so it masks offer and pop here.
    assign w_capturing = (r_state == S_ARMED) || (r_state == S_POST);
    assign w_offer     = trace_valid && w_capturing && !clear;
    assign w_pop       = (r_level != '0) && out_ready && !clear;
    assign w_push      = w_offer && ((r_level != FULL_LVL) || w_pop);
    assign w_drop      = w_offer && !w_push;
    assign w_match     = ((trace_instr ^ trig_instr) & trig_mask) == 32'd0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {trace_instr, trace_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (AW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - (AW + 1)'(1);
            end
            if (w_drop && (r_ovf != '1)) begin
                r_ovf <= r_ovf + OVF_W'(1);
            end
        end
    end

    // Dropped records still advance the trigger/post logic: w_offer, not w_push, drives it.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state     <= S_IDLE;
            r_post_cnt  <= '0;
            r_triggered <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (w_offer && w_match) begin
                        r_triggered <= 1'b1;
                        r_post_cnt  <= PCW'(POST_TRIG);
                        r_state     <= (POST_TRIG == 0) ? S_STOP : S_POST;
                    end
                end
                S_POST: begin
                    if (w_offer) begin
                        r_post_cnt <= r_post_cnt - PCW'(1);
                        if (r_post_cnt == PCW'(1)) begin
                            r_state <= S_STOP;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid      = (r_level != '0);
    assign out_instr      = out_valid ? r_mem[r_rd_ptr][63:32] : 32'd0;
    assign out_addr       = out_valid ? r_mem[r_rd_ptr][31:0]  : 32'd0;
    assign level          = r_level;
    assign overflow_count = r_ovf;
    assign triggered      = r_triggered;
    assign done           = (r_state == S_STOP);

endmodule
